// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_pkg
//  Description : Shared types and constants for the sprite layer mapper:
//                per-layer configuration struct, datapath widths and the
//                base/size table of the sprites stored in ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
package sprite_pkg;

    localparam int c_coord_w = 10;
    localparam int c_addr_w  = 18;
    localparam int c_idx_w   = 4;
    localparam int c_frame_w = 4;
    localparam int c_layer_w = 3;

    // Colour index that lets lower layers show through
    localparam logic [c_idx_w-1:0] c_transparent_idx = '0;

    // Sprite sheet locations in ROM (frames stored back to back)
    localparam int c_runner3_base = 0;
    localparam int c_runner3_w    = 88;
    localparam int c_runner3_h    = 94;
    localparam int c_runner4_base = 8272;
    localparam int c_runner4_w    = 88;
    localparam int c_runner4_h    = 94;
    localparam int c_cloud_base   = 16544;
    localparam int c_cloud_w      = 92;
    localparam int c_cloud_h      = 27;
    localparam int c_trex_base    = 207867;
    localparam int c_trex_w       = 88;
    localparam int c_trex_h       = 94;

    typedef struct packed {
        logic [c_coord_w-1:0] x;
        logic [c_coord_w-1:0] y;
        logic [c_coord_w-1:0] w;
        logic [c_coord_w-1:0] h;
        logic [c_addr_w-1:0]  base;
        logic [c_frame_w-1:0] num_frames;
        logic                 enable;
        logic                 flip;
    } layer_cfg_t;

    // Number of ROM words occupied by one animation frame
    function automatic int sprite_frame_size(input int w, input int h);
        return w * h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_anim_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_anim_ctr
//  Description : Per-layer animation counter. Divides frame_tick by ANIM_DIV
//                and steps frame_idx through 0..num_frames-1 (0 frames means
//                a static sprite). A shrunk num_frames resets the index on
//                the next step.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_anim_ctr
    import sprite_pkg::*;
#(
    parameter int ANIM_DIV = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_tick,
    input  logic [c_frame_w-1:0] num_frames,
    output logic [c_frame_w-1:0] frame_idx
);

    localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(ANIM_DIV - 1);

    logic [DIV_W-1:0]     r_div;
    logic [c_frame_w-1:0] r_frame_idx;
    logic [c_frame_w-1:0] w_last_frame;

    assign w_last_frame = (num_frames == '0) ? '0 : num_frames - 1'b1;
    assign frame_idx    = r_frame_idx;

    // Tick divider and frame index advance; reset overrides a concurrent tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div       <= '0;
            r_frame_idx <= '0;
        end else if (frame_tick) begin
            if (r_div == C_DIV_LAST) begin
                r_div       <= '0;
                r_frame_idx <= (r_frame_idx >= w_last_frame) ? '0 : r_frame_idx + 1'b1;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sprite_layer_mapper.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_layer_mapper
//  Description : Composites NUM_LAYERS animated rectangular sprites over the
//                raster. S0 registers per-layer hit and ROM address, S1 is the
//                ROM read, S2 registers the highest-priority opaque pixel.
//                DrawX/DrawY to pix_* latency is 3 clocks.
//                Optional macro SPRITE_MIRROR_EN enables horizontal flip.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_layer_mapper
    import sprite_pkg::*;
#(
    parameter int NUM_LAYERS      = 4,
    parameter int COORD_W         = c_coord_w,
    parameter int ADDR_W          = c_addr_w,
    parameter int IDX_W           = c_idx_w,
    parameter int ANIM_DIV        = 5,
    parameter int TRANSPARENT_IDX = 0
) (
    input  logic                                Clk,
    input  logic                                Reset,
    input  logic                                frame_tick,
    input  logic [COORD_W-1:0]                  DrawX,
    input  logic [COORD_W-1:0]                  DrawY,
    input  layer_cfg_t [NUM_LAYERS-1:0]         layer_cfg,
    output logic [NUM_LAYERS-1:0][ADDR_W-1:0]   rom_addr,
    input  logic [NUM_LAYERS-1:0][IDX_W-1:0]    rom_data,
    output logic [IDX_W-1:0]                    pix_idx,
    output logic                                pix_hit,
    output logic [c_layer_w-1:0]                pix_layer,
    output logic [COORD_W-1:0]                  pix_x,
    output logic [COORD_W-1:0]                  pix_y
);

    logic [NUM_LAYERS-1:0][c_frame_w-1:0] w_frame_idx;
    logic [NUM_LAYERS-1:0]                w_hit;
    logic [NUM_LAYERS-1:0][ADDR_W-1:0]    w_addr;

    logic [NUM_LAYERS-1:0]                r_hit0;
    logic [NUM_LAYERS-1:0]                r_hit1;
    logic [NUM_LAYERS-1:0][ADDR_W-1:0]    r_addr;
    logic [COORD_W-1:0]                   r_x0, r_x1, r_y0, r_y1;

    logic                                 w_win_hit;
    logic [IDX_W-1:0]                     w_win_idx;
    logic [c_layer_w-1:0]                 w_win_layer;

    assign rom_addr = r_addr;

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
        logic [COORD_W-1:0] w_dx, w_dy, w_col;
        logic [COORD_W:0]   w_x_end, w_y_end;
        logic [ADDR_W-1:0]  w_sum;

        sprite_anim_ctr #(
            .ANIM_DIV   (ANIM_DIV)
        ) u_anim (
            .clk        (Clk),
            .rst        (Reset),
            .frame_tick (frame_tick),
            .num_frames (layer_cfg[i].num_frames),
            .frame_idx  (w_frame_idx[i])
        );

        // Bounds at one extra bit so a sprite near the right edge cannot wrap
        assign w_x_end = {1'b0, layer_cfg[i].x} + {1'b0, layer_cfg[i].w};
        assign w_y_end = {1'b0, layer_cfg[i].y} + {1'b0, layer_cfg[i].h};
        assign w_dx    = DrawX - layer_cfg[i].x;
        assign w_dy    = DrawY - layer_cfg[i].y;

`ifdef SPRITE_MIRROR_EN
        assign w_col = layer_cfg[i].flip ? (layer_cfg[i].w - 1'b1 - w_dx) : w_dx;
`else
        // Mirroring not built in: flip has no effect on the column
        assign w_col = layer_cfg[i].flip ? w_dx : w_dx;
`endif

        assign w_hit[i] = layer_cfg[i].enable
                        && (layer_cfg[i].w != '0) && (layer_cfg[i].h != '0)
                        && (DrawX >= layer_cfg[i].x) && ({1'b0, DrawX} < w_x_end)
                        && (DrawY >= layer_cfg[i].y) && ({1'b0, DrawY} < w_y_end);

        assign w_sum = ADDR_W'(32'(layer_cfg[i].base)
                     + 32'(w_frame_idx[i]) * (32'(layer_cfg[i].w) * 32'(layer_cfg[i].h))
                     + 32'(w_dy) * 32'(layer_cfg[i].w)
                     + 32'(w_col));

        assign w_addr[i] = w_hit[i] ? w_sum : '0;
    end

    // Priority pick: scan top-down from the last layer so layer 0 wins last
    always_comb begin
        w_win_hit   = 1'b0;
        w_win_idx   = '0;
        w_win_layer = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (r_hit1[i] && (rom_data[i] != IDX_W'(TRANSPARENT_IDX))) begin
                w_win_hit   = 1'b1;
                w_win_idx   = rom_data[i];
                w_win_layer = c_layer_w'(i);
            end
        end
    end

    // Three-stage pipeline: S0 address/hit, S1 ROM wait, S2 result
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hit0    <= '0;
            r_hit1    <= '0;
            r_addr    <= '0;
            r_x0      <= '0;
            r_x1      <= '0;
            r_y0      <= '0;
            r_y1      <= '0;
            pix_hit   <= 1'b0;
            pix_idx   <= '0;
            pix_layer <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
        end else begin
            r_hit0    <= w_hit;
            r_addr    <= w_addr;
            r_hit1    <= r_hit0;
            r_x0      <= DrawX;
            r_x1      <= r_x0;
            r_y0      <= DrawY;
            r_y1      <= r_y0;
            pix_hit   <= w_win_hit;
            pix_idx   <= w_win_idx;
            pix_layer <= w_win_layer;
            pix_x     <= r_x1;
            pix_y     <= r_y1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_layer_mapper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_layer_mapper
//  Description : Scoreboard bench for sprite_layer_mapper with a 1-cycle ROM
//                model. Honours SPRITE_MIRROR_EN in its expected addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_layer_mapper;
    import sprite_pkg::*;

    localparam int NL = 4;
`ifdef SPRITE_MIRROR_EN
    localparam int MIR = 1;
`else
    localparam int MIR = 0;
`endif

    logic                      Clk = 1'b0;
    logic                      Reset;
    logic                      frame_tick;
    logic [9:0]                DrawX, DrawY;
    layer_cfg_t [NL-1:0]       layer_cfg;
    logic [NL-1:0][17:0]       rom_addr;
    logic [NL-1:0][3:0]        rom_data;
    logic [3:0]                pix_idx;
    logic                      pix_hit;
    logic [2:0]                pix_layer;
    logic [9:0]                pix_x, pix_y;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
        logic [2:0] layer;
        logic [9:0] x;
        logic [9:0] y;
    } pix_t;

    logic [NL-1:0][17:0] addr_q[$];
    pix_t                pix_q[$];
    logic [NL-1:0][3:0]  rv, rv_d;
    logic                issue = 1'b0;
    logic                v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
    int                  n_cmp = 0;
    int                  n_bad = 0;

    sprite_layer_mapper #(
        .NUM_LAYERS (NL)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .layer_cfg  (layer_cfg),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pix_idx    (pix_idx),
        .pix_hit    (pix_hit),
        .pix_layer  (pix_layer),
        .pix_x      (pix_x),
        .pix_y      (pix_y)
    );

    always #5 Clk = ~Clk;

    // ROM model: data chosen with the pixel, returned one clock after the address
    always @(posedge Clk) begin
        rv_d     <= rv;
        rom_data <= rv_d;
    end

    // Track when issued pixels reach the address and pixel outputs
    always @(posedge Clk) begin
        v1 <= issue;
        v2 <= v1;
        v3 <= v2;
    end

    // Monitor: pop and compare whenever an issued pixel is presented
    always @(negedge Clk) begin
        if (v1) begin
            if (addr_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL addr_q_empty got %h", rom_addr);
            end else begin
                logic [NL-1:0][17:0] ea;
                ea = addr_q.pop_front();
                n_cmp++;
                if (rom_addr !== ea) begin
                    n_bad++;
                    $display("FAIL rom_addr got %h exp %h", rom_addr, ea);
                end
            end
        end
        if (v3) begin
            if (pix_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL pix_q_empty got hit=%0d", pix_hit);
            end else begin
                pix_t ep, gp;
                ep = pix_q.pop_front();
                gp = {pix_hit, pix_idx, pix_layer, pix_x, pix_y};
                n_cmp++;
                if (gp !== ep) begin
                    n_bad++;
                    $display("FAIL pix got hit=%0d idx=%0d layer=%0d x=%0d y=%0d exp hit=%0d idx=%0d layer=%0d x=%0d y=%0d",
                             gp.hit, gp.idx, gp.layer, gp.x, gp.y, ep.hit, ep.idx, ep.layer, ep.x, ep.y);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    // Issue one pixel with its ROM data and push its expected response
    task automatic px(input int x, input int y, input logic [15:0] rvp,
                      input int a0, input int a1, input int a2, input int a3,
                      input logic h, input int idx, input int lay);
        logic [NL-1:0][17:0] ea;
        pix_t ep;
        @(negedge Clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        rv    = rvp;
        issue = 1'b1;
        ea[0] = 18'(a0); ea[1] = 18'(a1); ea[2] = 18'(a2); ea[3] = 18'(a3);
        ep.hit = h; ep.idx = 4'(idx); ep.layer = 3'(lay); ep.x = 10'(x); ep.y = 10'(y);
        addr_q.push_back(ea);
        pix_q.push_back(ep);
    endtask

    task automatic idle(input int n);
        @(negedge Clk);
        issue = 1'b0;
        repeat (n) @(negedge Clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge Clk);
            issue      = 1'b0;
            frame_tick = 1'b1;
            @(negedge Clk);
            frame_tick = 1'b0;
        end
    endtask

    function automatic int col2(input int dx);
        return (MIR != 0) ? (91 - dx) : dx;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1; frame_tick = 1'b0; DrawX = '0; DrawY = '0; rv = 16'hFFFF;
        layer_cfg[0] = '{x:10'd100, y:10'd200, w:10'd88, h:10'd94, base:18'd207867,
                         num_frames:4'd2, enable:1'b1, flip:1'b0};
        layer_cfg[1] = '{x:10'd150, y:10'd210, w:10'd50, h:10'd50, base:18'd1000,
                         num_frames:4'd1, enable:1'b1, flip:1'b0};
        layer_cfg[2] = '{x:10'd600, y:10'd100, w:10'd92, h:10'd10, base:18'd5000,
                         num_frames:4'd0, enable:1'b1, flip:1'b1};
        layer_cfg[3] = '{x:10'd0, y:10'd0, w:10'd10, h:10'd10, base:18'd300,
                         num_frames:4'd1, enable:1'b0, flip:1'b0};
        repeat (3) @(negedge Clk);
        chk("reset_pix_hit", 32'(pix_hit), 0);
        chk("reset_pix_idx", 32'(pix_idx), 0);
        chk("reset_rom_addr0", 32'(rom_addr[0]), 0);
        Reset = 1'b0;

        // Bounds, priority and transparency
        px(100, 200, 16'hFFF7, 207867, 0, 0, 0, 1'b1, 7, 0);
        px(187, 200, 16'hFFF7, 207954, 0, 0, 0, 1'b1, 7, 0);
        px(188, 200, 16'hFFFF, 0, 0, 0, 0, 1'b0, 0, 0);
        px(100, 200, 16'hFFF0, 207867, 0, 0, 0, 1'b0, 0, 0);
        px(150, 210, 16'hFF50, 208797, 1000, 0, 0, 1'b1, 5, 1);
        px(150, 210, 16'hFF53, 208797, 1000, 0, 0, 1'b1, 3, 0);
        px(5,   100, 16'hF9FF, 0, 0, 0, 0, 1'b0, 0, 0);
        px(639, 100, 16'hF9FF, 0, 0, 5000 + col2(39), 0, 1'b1, 9, 2);
        px(600, 100, 16'hF9FF, 0, 0, 5000 + col2(0), 0, 1'b1, 9, 2);
        px(691, 109, 16'hF9FF, 0, 0, 5000 + 828 + col2(91), 0, 1'b1, 9, 2);
        px(692, 109, 16'hF9FF, 0, 0, 0, 0, 1'b0, 0, 0);
        px(600, 110, 16'hF9FF, 0, 0, 0, 0, 1'b0, 0, 0);
        px(599, 100, 16'hF9FF, 0, 0, 0, 0, 1'b0, 0, 0);
        px(0,   0,   16'h1FFF, 0, 0, 0, 0, 1'b0, 0, 0);
        idle(5);

        // Animation: 5 ticks per step, two frames of 88*94 words
        ticks(4);
        px(100, 200, 16'hFFF7, 207867, 0, 0, 0, 1'b1, 7, 0);
        idle(5);
        ticks(1);
        px(100, 200, 16'hFFF7, 216139, 0, 0, 0, 1'b1, 7, 0);
        idle(5);
        ticks(5);
        px(100, 200, 16'hFFF7, 207867, 0, 0, 0, 1'b1, 7, 0);
        idle(5);

        // Reset mid-line while on frame 1, with a concurrent frame_tick
        ticks(5);
        @(negedge Clk);
        DrawX = 10'd100; DrawY = 10'd200; rv = 16'hFFF7; issue = 1'b0;
        repeat (4) @(negedge Clk);
        chk("pre_rst_hit", 32'(pix_hit), 1);
        chk("pre_rst_addr", 32'(rom_addr[0]), 216139);
        Reset = 1'b1; frame_tick = 1'b1;
        @(negedge Clk);
        chk("rst_hit0", 32'(pix_hit), 0);
        chk("rst_addr_clr", 32'(rom_addr[0]), 0);
        Reset = 1'b0; frame_tick = 1'b0;
        @(negedge Clk);
        chk("rst_frame0_addr", 32'(rom_addr[0]), 207867);
        chk("rst_hit1", 32'(pix_hit), 0);
        @(negedge Clk);
        chk("rst_hit2", 32'(pix_hit), 0);
        @(negedge Clk);
        chk("rst_resume_hit", 32'(pix_hit), 1);

        // Divider restarted from 0: four ticks keep frame 0, the fifth advances
        ticks(4);
        @(negedge Clk);
        chk("div_rst_4ticks", 32'(rom_addr[0]), 207867);
        ticks(1);
        @(negedge Clk);
        chk("div_rst_5ticks", 32'(rom_addr[0]), 216139);

        idle(2);
        chk("queues_drained", 32'(addr_q.size() + pix_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
